seq_bit_transmitter: RTL and testbench
======================================

// Module: seq_bit_transmitter
// PURPOSE
//  Serial pattern source for the Mealy sequence-detector path. It accepts a parallel bit pattern
//  through a valid/ready handshake and drives it one bit per clock on a serial line, MSB first.
//  It then inserts an idle gap before accepting the next pattern.
//  It produces the `in` stream that the sequence detector consumes, for on-chip self-test and stimulus.
// PARAMETERS
//  WIDTH       8   maximum pattern length in bits (>=2)
//  LEN_W       4   width of len port; must satisfy 2**LEN_W > WIDTH
//  GAP_CYCLES  2   idle cycles after each pattern (0 allowed = back-to-back)
//  IDLE_LEVEL  0   value driven on out while not transmitting
// PORTS
//  clk          in   1      rising-edge clock
//  RESET        in   1      asynchronous, active-high reset
//  start_valid  in   1      request to send pattern/len
//  start_ready  out  1      block can accept a request
//  pattern      in   WIDTH  bits to send; pattern[len-1] first, pattern[0] last
//  len          in   LEN_W  number of bits; 0 or >WIDTH is treated as WIDTH
//  out          out  1      serial data (registered)
//  out_valid    out  1      out carries a pattern/parity bit this cycle
//  busy         out  1      not in IDLE
//  done         out  1      one-cycle pulse on completion of a pattern including its gap
// BEHAVIOUR
//  Reset (asynchronous, any cycle): state=IDLE; out=IDLE_LEVEL; out_valid=0; busy=0; done=0; start_ready=1.
//  Reset mid-transmission aborts the pattern immediately. No done pulse is issued.
//  FSM states: IDLE, SHIFT, PARITY (macro only), GAP.
//   IDLE: start_ready=1. Accept on the edge where start_valid&start_ready is high.
//     On accept: latch pattern left-aligned into shreg (WIDTH bits); bit counter=eff_len; go to SHIFT.
//   SHIFT: out=shreg[MSB] and out_valid=1, registered, so the first bit appears the cycle after accept.
//     shreg shifts left each cycle and the counter decrements. After eff_len bits:
//     go to PARITY if the macro is defined, otherwise go to GAP (or IDLE if GAP_CYCLES=0).
//   GAP: out=IDLE_LEVEL, out_valid=0, for exactly GAP_CYCLES cycles, then go to IDLE.
//   done pulses for 1 cycle coincident with the first IDLE cycle after the pattern.
//   When GAP_CYCLES=0, done pulses in the cycle after the last data or parity bit.
//  Latency: accept edge k -> first bit valid in cycle k+1 -> last bit in cycle k+eff_len.
//  start_ready=0 in every non-IDLE state. Requests presented while busy are held off and not lost.
//  pattern and len are sampled only at the accept edge. Later changes are ignored.
//  A request may be accepted in the same cycle as the done pulse (IDLE with start_ready=1).
//  Back-to-back patterns with GAP_CYCLES=0 therefore have exactly one idle cycle between them.
//  Bits above len-1 in pattern are ignored. len=1 sends pattern[0] only.
//  The counter has no wrap-around: the FSM leaves SHIFT exactly when the count reaches 0.
// CONFIGURATION
//  SEQ_TX_PARITY_EN defined:
//   After the data bits, one PARITY cycle drives out = XOR of all transmitted data bits
//   (even parity), with out_valid=1. Latency to done grows by 1.
//  SEQ_TX_PARITY_EN undefined:
//   The PARITY state and the parity accumulator are absent. SHIFT goes directly to GAP/IDLE.
// STRUCTURE
//  Package seq_tx_pkg:
//   - state encoding localparams ST_IDLE/ST_SHIFT/ST_PARITY/ST_GAP
//   - function eff_len(len, WIDTH) that clamps len
//   - gap counter width = $clog2(GAP_CYCLES+1)
//  Sub-module seq_tx_shifter: left-aligned load, shift-left, bit counter, and last_bit flag.
//  The top level holds the FSM, gap counter, parity accumulator, and output registers.
// TESTING
//  1. pattern=8'h09, len=4, GAP=2: out_valid 4 cycles with out=1,0,0,1; then 2 gap cycles; then done.
//  2. len=0, pattern=8'hA5: 8 bits 1,0,1,0,0,1,0,1 sent; len=1, pattern=8'h01: single bit 1.
//  3. start_valid held during busy, pattern changed mid-send: first pattern sent intact;
//     second accepted on the done cycle.
//  4. RESET asserted in 3rd SHIFT cycle: outputs reach reset values asynchronously;
//     no done pulse; next request is sent from bit 0.
//  5. SEQ_TX_PARITY_EN, pattern=4'b1011, len=4: bits 1,0,1,1 then parity 1; done 1 cycle later than without the macro.
//  6. GAP_CYCLES=0, continuous start_valid: stream 1,0,0,1,gap,1,0,0,1,...; done each pattern.
//     Feeding out into the detector gives the expected detection pulses.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Optional parity bit is enabled by defining SEQ_TX_PARITY_EN.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_GAP    = 2'd3
   } state_e;

   // A length of 0, or one longer than the pattern register, means "send all WIDTH bits".
   function automatic int eff_len(input int len, input int width);
      return (len == 0 || len > width) ? width : len;
   endfunction

   function automatic int gap_cnt_w(input int gap_cycles);
      return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
   endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Pattern shift register: left-aligned load, shift-left per bit, remaining-bit counter.
// Optional parity bit (SEQ_TX_PARITY_EN) lives in the top level, not here.
module seq_tx_shifter
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             first_bit_o,
   output logic             next_bit_o,
   output logic             last_bit_o
);

   int               shamt;
   logic [WIDTH-1:0] aligned;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   // Left-aligning pushes bits above len-1 out of the register.
   always_comb begin
      shamt   = WIDTH - eff_len(int'(len_i), WIDTH);
      aligned = pattern_i << shamt;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = aligned;
         cnt_d   = LEN_W'(eff_len(int'(len_i), WIDTH));
      end else if (shift_i && cnt_q != '0) begin
         shreg_d = shreg_q << 1;
         cnt_d   = cnt_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign first_bit_o = aligned[WIDTH-1];
   assign next_bit_o  = shreg_q[WIDTH-2];
   assign last_bit_o  = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_bit_transmitter.sv
// Serial pattern source: accepts a pattern by valid/ready, sends it MSB first, then idles a gap.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the data bits.
module seq_bit_transmitter
   import seq_tx_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   LEN_W      = 4,
   parameter int   GAP_CYCLES = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int              GW       = gap_cnt_w(GAP_CYCLES);
   localparam state_e          POST     = state_e'((GAP_CYCLES == 0) ? ST_IDLE : ST_GAP);
   localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic            POST_DONE = (GAP_CYCLES == 0);

   state_e        state_q;
   logic [GW-1:0] gap_q;
   logic          out_q, ov_q, done_q;
   logic          first_bit, next_bit, last_bit;
`ifdef SEQ_TX_PARITY_EN
   logic          par_q;
`endif

   seq_tx_shifter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shifter (
      .clk_i      (clk),
      .rst_i      (RESET),
      .load_i     (state_q == ST_IDLE && start_valid),
      .shift_i    (state_q == ST_SHIFT),
      .pattern_i  (pattern),
      .len_i      (len),
      .first_bit_o(first_bit),
      .next_bit_o (next_bit),
      .last_bit_o (last_bit)
   );

   // Outputs are registered alongside the state so each bit shows the cycle after its edge.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         out_q   <= IDLE_LEVEL;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start_valid) begin
               state_q <= ST_SHIFT;
               out_q   <= first_bit;
               ov_q    <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
               par_q   <= first_bit;
`endif
            end
            ST_SHIFT: if (last_bit) begin
`ifdef SEQ_TX_PARITY_EN
               state_q <= ST_PARITY;
               out_q   <= par_q;
               ov_q    <= 1'b1;
`else
               state_q <= POST;
               gap_q   <= GAP_LOAD;
               done_q  <= POST_DONE;
               out_q   <= IDLE_LEVEL;
               ov_q    <= 1'b0;
`endif
            end else begin
               out_q <= next_bit;
`ifdef SEQ_TX_PARITY_EN
               par_q <= par_q ^ next_bit;
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
               state_q <= POST;
               gap_q   <= GAP_LOAD;
               done_q  <= POST_DONE;
               out_q   <= IDLE_LEVEL;
               ov_q    <= 1'b0;
            end
`endif
            ST_GAP: if (gap_q == '0) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end else begin
               gap_q <= gap_q - GW'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out         = out_q;
   assign out_valid   = ov_q;
   assign done        = done_q;
   assign busy        = (state_q != ST_IDLE);
   assign start_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_seq_bit_transmitter.sv
// Directed bench for seq_bit_transmitter: GAP_CYCLES=2 and GAP_CYCLES=0 instances.
// Expectations follow SEQ_TX_PARITY_EN when the macro is defined for the build.
module tb_seq_bit_transmitter;

`ifdef SEQ_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       RESET = 1'b1;
   logic       sv = 1'b0, sv0 = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] len = '0;
   logic       rdy, out, ov, busy, done;
   logic       rdy0, out0, ov0, busy0, done0;
   int         ntot = 0, npass = 0;

   always #5 clk = ~clk;

   seq_bit_transmitter #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut (
      .clk(clk), .RESET(RESET), .start_valid(sv), .start_ready(rdy),
      .pattern(pattern), .len(len), .out(out), .out_valid(ov), .busy(busy), .done(done));

   seq_bit_transmitter #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut0 (
      .clk(clk), .RESET(RESET), .start_valid(sv0), .start_ready(rdy0),
      .pattern(pattern), .len(len), .out(out0), .out_valid(ov0), .busy(busy0), .done(done0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Observed vector {out_valid, out, busy, start_ready, done}
   function automatic logic [4:0] obs(input bit g0);
      return g0 ? {ov0, out0, busy0, rdy0, done0} : {ov, out, busy, rdy, done};
   endfunction

   // Called right after the accept edge; seq[i] is the i-th bit expected on the line.
   task automatic frame(input string tag, input bit g0, input int n, input logic [7:0] seq,
                        input logic par);
      int gap;
      logic [4:0] exp;
      gap = g0 ? 0 : 2;
      for (int i = 0; i <= n + P + gap; i++) begin
         @(negedge clk);
         if (i < n)                exp = {1'b1, seq[i], 1'b1, 1'b0, 1'b0};
         else if (P == 1 && i == n) exp = {1'b1, par, 1'b1, 1'b0, 1'b0};
         else if (i < n + P + gap) exp = 5'b00100;
         else                      exp = 5'b00011;
         chk($sformatf("%s_c%0d", tag, i), 32'(obs(g0)), 32'(exp));
      end
   endtask

   task automatic send(input logic [7:0] p, input logic [3:0] l);
      @(negedge clk);
      sv = 1'b1; pattern = p; len = l;
      @(posedge clk);
      #1 sv = 1'b0; pattern = 8'h5A; len = 4'd3;
   endtask

   initial begin
      #3;
      chk("rst_main", 32'(obs(1'b0)), 32'h02);
      chk("rst_gap0", 32'(obs(1'b1)), 32'h02);
      @(negedge clk); RESET = 1'b0;

      // Basic 4-bit frame, then boundaries on len
      send(8'h09, 4'd4);  frame("t1_09", 1'b0, 4, 8'h09, 1'b0);
      send(8'hA5, 4'd0);  frame("t2_len0", 1'b0, 8, 8'hA5, 1'b0);
      send(8'h01, 4'd1);  frame("t2_len1", 1'b0, 1, 8'h01, 1'b1);
      send(8'hFE, 4'd1);  frame("t2_hi_ign", 1'b0, 1, 8'h00, 1'b0);
      send(8'hF0, 4'd3);  frame("t2_len3", 1'b0, 3, 8'h00, 1'b0);
      send(8'h81, 4'd12); frame("t2_len12", 1'b0, 8, 8'h81, 1'b0);
      send(8'h0B, 4'd4);  frame("t5_1011", 1'b0, 4, 8'h0D, 1'b1);

      // Request held while busy with pattern changed mid-send
      @(negedge clk); sv = 1'b1; pattern = 8'h09; len = 4'd4;
      @(posedge clk); #1 pattern = 8'hA5; len = 4'd0;
      frame("t3_first", 1'b0, 4, 8'h09, 1'b0);
      @(posedge clk); #1 sv = 1'b0;
      frame("t3_second", 1'b0, 8, 8'hA5, 1'b0);

      // Reset in the third shift cycle
      send(8'h0F, 4'd4);
      @(posedge clk); @(posedge clk);
      #2 chk("t4_pre", 32'(obs(1'b0)), 32'h1C);
      RESET = 1'b1;
      #1 chk("t4_async", 32'(obs(1'b0)), 32'h02);
      @(negedge clk); RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t4_nodone%0d", i), 32'(obs(1'b0)), 32'h02);
      end
      send(8'h09, 4'd4); frame("t4_after", 1'b0, 4, 8'h09, 1'b0);

      // Zero-gap instance with continuous requests
      @(negedge clk); sv0 = 1'b1; pattern = 8'h09; len = 4'd4;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 2) sv0 = 1'b0;
         frame($sformatf("t6_f%0d", k), 1'b1, 4, 8'h09, 1'b0);
      end
      @(negedge clk);
      chk("t6_idle", 32'(obs(1'b1)), 32'h02);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
